// File: rtl/asynch_fifo_pkg.sv
// Shared defaults and pointer-width helper for the single-clock FIFO.
package asynch_fifo_pkg;

   localparam int DEFAULT_DEPTH      = 16;
   localparam int DEFAULT_DATA_WIDTH = 8;

   // Address bits needed to index DEPTH entries; pointers carry one extra wrap bit.
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port and one registered synchronous read port.
module fifo_mem #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // The array itself is never reset; only the output register is.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/asynch_fifo.sv
// Single-clock FIFO: wrap-bit pointers, combinational full/empty, registered over/underflow.
module asynch_fifo
   import asynch_fifo_pkg::*;
#(
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  full_o,
   output logic                  overflow_o,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  empty_o,
   output logic                  underflow_o
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic           wr_accept;
   logic           rd_accept;

   // Equal addresses mean empty when the wrap bits agree and full when they differ.
   assign empty_o   = (wr_ptr == rd_ptr);
   assign full_o    = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                      (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
   assign wr_accept = wr_en_i && !full_o;
   assign rd_accept = rd_en_i && !empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
         overflow_o  <= wr_en_i && full_o;
         underflow_o <= rd_en_i && empty_o;
      end
   end

   fifo_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (PTR_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr[PTR_W-1:0]),
      .wr_data (wdata_i),
      .rd_en   (rd_accept),
      .rd_addr (rd_ptr[PTR_W-1:0]),
      .rd_data (rdata_o)
   );

endmodule

// File: tb/tb_asynch_fifo.sv
// Directed-plus-random bench for asynch_fifo against a queue-based occupancy model.
module tb_asynch_fifo;

   localparam int DEPTH = 16;
   localparam int DW    = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          wr_en_i = 1'b0;
   logic [DW-1:0] wdata_i = '0;
   logic          rd_en_i = 1'b0;
   logic          full_o, overflow_o, empty_o, underflow_o;
   logic [DW-1:0] rdata_o;

   int n_pass = 0;
   int n_total = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_rdata = '0;
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;

   always #10 clk = ~clk;

   asynch_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en_i     (wr_en_i),
      .wdata_i     (wdata_i),
      .full_o      (full_o),
      .overflow_o  (overflow_o),
      .rd_en_i     (rd_en_i),
      .rdata_o     (rdata_o),
      .empty_o     (empty_o),
      .underflow_o (underflow_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".empty"},     {31'd0, empty_o},     {31'd0, q.size() == 0});
      chk({tag, ".full"},      {31'd0, full_o},      {31'd0, q.size() == DEPTH});
      chk({tag, ".overflow"},  {31'd0, overflow_o},  {31'd0, m_ovf});
      chk({tag, ".underflow"}, {31'd0, underflow_o}, {31'd0, m_unf});
      chk({tag, ".rdata"},     {24'd0, rdata_o},     {24'd0, m_rdata});
   endtask

   // One clock: apply inputs (optionally staggered within the cycle), model the edge, check at edge+1.
   task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d,
                       input int wdly, input int rdly, input string tag);
      bit was_full, was_empty;
      #(wdly);
      wr_en_i = wr;
      wdata_i = d;
      #(rdly - wdly);
      rd_en_i = rd;
      @(posedge clk);
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ovf = wr && was_full;
      m_unf = rd && was_empty;
      if (rd && !was_empty) m_rdata = q.pop_front();
      if (wr && !was_full)  q.push_back(d);
      #1;
      chk_all(tag);
   endtask

   task automatic wr1(input string tag);
      step(1'b1, 1'b0, DW'($urandom), 0, 0, tag);
   endtask

   task automatic rd1(input string tag);
      step(1'b0, 1'b1, '0, 0, 0, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset, checked before any clock edge acts
      #3 rst_n = 1'b0;
      #1 chk_all("reset");
      @(posedge clk);
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill to full
      for (int i = 0; i < DEPTH; i++) wr1("fill16");
      // Drain in order
      for (int i = 0; i < DEPTH; i++) rd1("drain16");

      // Three writes beyond full are dropped
      for (int i = 0; i < DEPTH + 3; i++) wr1("over19");
      for (int i = 0; i < DEPTH; i++) rd1("over_drain");

      // Two reads beyond empty: underflow pulses, rdata holds
      for (int i = 0; i < DEPTH; i++) wr1("under_fill");
      for (int i = 0; i < DEPTH + 2; i++) rd1("under18");

      // Overlapping streams with inputs changing mid-cycle
      for (int i = 0; i <= DEPTH; i++)
         step(i < DEPTH, i > 0, DW'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(6, 10)), "stream");

      // Simultaneous read/write at empty, then at full
      step(1'b1, 1'b1, DW'($urandom), 0, 0, "rw_empty");
      while (q.size() < DEPTH) wr1("refill");
      step(1'b1, 1'b1, DW'($urandom), 0, 0, "rw_full");
      step(1'b1, 1'b1, DW'($urandom), 0, 0, "rw_mid");

      // Random mixed traffic
      for (int i = 0; i < 80; i++)
         step(1'($urandom), 1'($urandom), DW'($urandom), 0, 0, "random");

      // Reset mid-operation with 8 entries held
      while (q.size() > 0) rd1("pre_rst_drain");
      for (int i = 0; i < 8; i++) wr1("pre_rst_fill");
      #4 rst_n = 1'b0;
      q.delete();
      m_rdata = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      #1 chk_all("mid_reset");
      #4 rst_n = 1'b1;
      wr1("post_rst_wr");
      rd1("post_rst_rd");

      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
